// File: rtl/mem_bus_arbiter.sv
// Shared-memory arbiter: N byte-wide masters onto internal RAM and IO space.
// Round-robin arbitration, locked bursts, debug preemption, and a tracked
// one-cycle read return that is routed back to the master that issued it.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH   = 3,
  parameter int DBG_MASTER     = NUM_MASTERS - 1
) (
  input  logic                              clk_in,
  input  logic                              rstn_in,
  input  logic                              dbg_active,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  input  logic [NUM_MASTERS-1:0]            m_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
  input  logic [NUM_MASTERS*8-1:0]          m_wdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [7:0]                        m_rdata,
  output logic                              ram_en,
  output logic                              ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_a,
  output logic [7:0]                        ram_d,
  input  logic [7:0]                        ram_q,
  output logic                              io_en,
  output logic                              io_wr,
  output logic [IO_SEL_WIDTH-1:0]           io_sel,
  output logic [7:0]                        io_d,
  input  logic [7:0]                        io_q
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam logic [IDX_W:0] N_EXT   = (IDX_W + 1)'(NUM_MASTERS);
  localparam idx_t           DBG_IDX = IDX_W'(DBG_MASTER);

  typedef enum logic [1:0] {ST_ARB, ST_LOCKED, ST_DBG} state_t;

  state_t         state_reg, state_next;
  idx_t           rr_ptr_reg, rr_ptr_next;
  idx_t           owner_reg, owner_next;
  idx_t           rd_owner_reg;
  logic           rd_pend_reg;
  logic           rd_io_reg;
  logic           run_reg;      // low while in reset; gates all combinational outputs

  logic           grant_vld;
  idx_t           grant_idx;
  logic [IDX_W:0] cand;
  logic [IDX_W:0] rr_inc;

  logic [ADDR_WIDTH-1:0] a_arr  [NUM_MASTERS];
  logic [7:0]            wd_arr [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] sel_a;
  logic [7:0]            sel_wd;
  logic                  sel_wr;
  logic                  is_io;
  logic                  unused_addr_bits;

  // Unpack the per-master address/data buses and build the one-hot outputs.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign a_arr[gi]    = m_a[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd_arr[gi]   = m_wdata[gi*8 +: 8];
      assign m_ack[gi]    = grant_vld && (grant_idx == idx_t'(gi));
      assign m_rvalid[gi] = run_reg && rd_pend_reg && (rd_owner_reg == idx_t'(gi));
    end
  endgenerate

  // Grant selection and next-state logic; debug overrides any lock in the same cycle.
  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = '0;
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    cand        = '0;
    rr_inc      = '0;
    if (!run_reg) begin
      state_next = ST_ARB;
    end else if (dbg_active) begin
      // A locked burst of another master is dropped here without an ack.
      state_next = ST_DBG;
      if (m_req[DBG_MASTER]) begin
        grant_vld = 1'b1;
        grant_idx = DBG_IDX;
      end
    end else if (state_reg == ST_LOCKED) begin
      if (m_req[owner_reg]) begin
        grant_vld  = 1'b1;
        grant_idx  = owner_reg;
        state_next = m_lock[owner_reg] ? ST_LOCKED : ST_ARB;
      end else begin
        state_next = ST_ARB;
      end
    end else begin
      // ARB, or DBG just released: scan downward so the requester closest
      // to rr_ptr is the last one written and therefore wins.
      state_next = ST_ARB;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        cand = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(k);
        if (cand >= N_EXT) cand = cand - N_EXT;
        if (m_req[cand[IDX_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[IDX_W-1:0];
        end
      end
      if (grant_vld) begin
        rr_inc = {1'b0, grant_idx} + 1'b1;
        if (rr_inc >= N_EXT) rr_inc = '0;
        rr_ptr_next = rr_inc[IDX_W-1:0];
        if (m_lock[grant_idx]) begin
          state_next = ST_LOCKED;
          owner_next = grant_idx;
        end
      end
    end
  end

  // Route the granted master onto the RAM or IO port depending on the address region.
  always_comb begin
    sel_a  = a_arr[grant_idx];
    sel_wd = wd_arr[grant_idx];
    sel_wr = m_wr[grant_idx];
    is_io  = (sel_a[RAM_ADDR_WIDTH -: 2] == 2'b11);
    ram_en = grant_vld && !is_io;
    io_en  = grant_vld && is_io;
    ram_wr = ram_en && sel_wr;
    io_wr  = io_en && sel_wr;
    ram_a  = ram_en ? sel_a[RAM_ADDR_WIDTH-1:0] : '0;
    ram_d  = ram_en ? sel_wd : 8'h00;
    io_sel = io_en ? sel_a[IO_SEL_WIDTH-1:0] : '0;
    io_d   = io_en ? sel_wd : 8'h00;
  end

  // Upper address bits only matter for the region decode.
  assign unused_addr_bits = ^sel_a;

  // Read return mux: the byte belongs to whichever port the read was issued on.
  assign m_rdata = (run_reg && rd_pend_reg) ? (rd_io_reg ? io_q : ram_q) : 8'h00;

  // State, round-robin pointer, lock owner and read-return tracking.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      run_reg      <= 1'b0;
      state_reg    <= ST_ARB;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      rd_pend_reg  <= 1'b0;
      rd_owner_reg <= '0;
      rd_io_reg    <= 1'b0;
    end else begin
      run_reg     <= 1'b1;
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      owner_reg   <= owner_next;
      rd_pend_reg <= grant_vld && !sel_wr;
      if (grant_vld) begin
        rd_owner_reg <= grant_idx;
        rd_io_reg    <= is_io;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a two-master and a three-master
// instance share clock and reset; each task drives one scenario and checks it.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rstn_in = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] ram_q = 8'h00;
  logic [7:0] io_q  = 8'h00;

  // two-master instance
  logic        dbg2 = 1'b0;
  logic [1:0]  req2 = '0, lock2 = '0, wr2 = '0;
  logic [63:0] a2 = '0;
  logic [15:0] wd2 = '0;
  logic [1:0]  ack2, rv2;
  logic [7:0]  rdata2, ram_d2, io_d2;
  logic        ram_en2, ram_wr2, io_en2, io_wr2;
  logic [16:0] ram_a2;
  logic [2:0]  io_sel2;

  // three-master instance, master 2 is the debug master
  logic        dbg3 = 1'b0;
  logic [2:0]  req3 = '0, lock3 = '0, wr3 = '0;
  logic [95:0] a3 = '0;
  logic [23:0] wd3 = '0;
  logic [2:0]  ack3, rv3;
  logic [7:0]  rdata3, ram_d3, io_d3;
  logic        ram_en3, ram_wr3, io_en3, io_wr3;
  logic [16:0] ram_a3;
  logic [2:0]  io_sel3;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_MASTERS(2)) u_dut2 (
    .clk_in(clk), .rstn_in(rstn_in), .dbg_active(dbg2),
    .m_req(req2), .m_lock(lock2), .m_wr(wr2), .m_a(a2), .m_wdata(wd2),
    .m_ack(ack2), .m_rvalid(rv2), .m_rdata(rdata2),
    .ram_en(ram_en2), .ram_wr(ram_wr2), .ram_a(ram_a2), .ram_d(ram_d2), .ram_q(ram_q),
    .io_en(io_en2), .io_wr(io_wr2), .io_sel(io_sel2), .io_d(io_d2), .io_q(io_q)
  );

  mem_bus_arbiter #(.NUM_MASTERS(3), .DBG_MASTER(2)) u_dut3 (
    .clk_in(clk), .rstn_in(rstn_in), .dbg_active(dbg3),
    .m_req(req3), .m_lock(lock3), .m_wr(wr3), .m_a(a3), .m_wdata(wd3),
    .m_ack(ack3), .m_rvalid(rv3), .m_rdata(rdata3),
    .ram_en(ram_en3), .ram_wr(ram_wr3), .ram_a(ram_a3), .ram_d(ram_d3), .ram_q(ram_q),
    .io_en(io_en3), .io_wr(io_wr3), .io_sel(io_sel3), .io_d(io_d3), .io_q(io_q)
  );

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset for one edge; returns at the start of the first running cycle.
  task automatic do_reset();
    rstn_in = 1'b0;
    req2 = '0; lock2 = '0; wr2 = '0; dbg2 = 1'b0;
    req3 = '0; lock3 = '0; wr3 = '0; dbg3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn_in = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rstn_in = 1'b0;
    req2 = 2'b11; lock2 = '0; wr2 = '0;
    a2 = {32'h0000_0020, 32'h0000_0010};
    repeat (2) @(negedge clk);
    total++;
    if ({ack2, rv2, rdata2, ram_en2, ram_wr2, ram_a2, ram_d2, io_en2, io_wr2, io_sel2, io_d2} !== '0) begin
      bad++;
      $display("FAIL reset_outputs ack=%b rv=%b rdata=%h ram_en=%b io_en=%b ram_a=%h required all zero",
               ack2, rv2, rdata2, ram_en2, io_en2, ram_a2);
    end
    $display("reset held: ack=%b ram_en=%b io_en=%b", ack2, ram_en2, io_en2);
    rstn_in = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if ({ack2, ram_en2, ram_a2} !== {2'b01, 1'b1, 17'h00010}) begin
      bad++;
      $display("FAIL reset_first_grant ack=%b ram_en=%b ram_a=%h required 01/1/00010", ack2, ram_en2, ram_a2);
    end
    $display("after release: ack=%b ram_a=%h", ack2, ram_a2);
    next_cycle();
    @(negedge clk);
    total++;
    if ({ack2, rv2} !== {2'b10, 2'b01}) begin
      bad++;
      $display("FAIL reset_rr_ptr ack=%b rv=%b required ack=10 rv=01", ack2, rv2);
    end
    $display("second grant: ack=%b rv=%b", ack2, rv2);
    req2 = '0;
  endtask

  task automatic test_fairness();
    logic [1:0] exp_ack, exp_rv;
    logic [7:0] exp_rd;
    logic [16:0] exp_a;
    do_reset();
    req2 = 2'b11; wr2 = '0;
    a2 = {32'h0000_0020, 32'h0000_0010};
    for (int i = 0; i < 6; i++) begin
      ram_q = 8'(8'h50 + i);
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_rv  = (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10);
      exp_rd  = (i == 0) ? 8'h00 : 8'(8'h50 + i);
      exp_a   = (i % 2 == 0) ? 17'h00010 : 17'h00020;
      @(negedge clk);
      total++;
      if ({ack2, rv2, rdata2, ram_a2} !== {exp_ack, exp_rv, exp_rd, exp_a}) begin
        bad++;
        $display("FAIL fair_cycle%0d ack=%b rv=%b rdata=%h ram_a=%h required %b %b %h %h",
                 i, ack2, rv2, rdata2, ram_a2, exp_ack, exp_rv, exp_rd, exp_a);
      end
      $display("fair cycle %0d: ack=%b rv=%b rdata=%h", i, ack2, rv2, rdata2);
      next_cycle();
    end
    req2 = '0; ram_q = 8'h77;
    @(negedge clk);
    total++;
    if ({ack2, rv2, rdata2} !== {2'b00, 2'b10, 8'h77}) begin
      bad++;
      $display("FAIL fair_tail ack=%b rv=%b rdata=%h required 00 10 77", ack2, rv2, rdata2);
    end
    $display("fair tail: ack=%b rv=%b rdata=%h", ack2, rv2, rdata2);
    next_cycle();
  endtask

  task automatic test_decode();
    do_reset();
    ram_q = 8'hC3; io_q = 8'h3C;
    req2 = 2'b01; wr2 = 2'b00; a2 = {32'h0, 32'h0003_0004};
    @(negedge clk);
    total++;
    if ({ack2, io_en2, io_wr2, io_sel2, ram_en2} !== {2'b01, 1'b1, 1'b0, 3'd4, 1'b0}) begin
      bad++;
      $display("FAIL decode_io ack=%b io_en=%b io_wr=%b io_sel=%0d ram_en=%b required 01 1 0 4 0",
               ack2, io_en2, io_wr2, io_sel2, ram_en2);
    end
    $display("io read: io_en=%b io_sel=%0d", io_en2, io_sel2);
    next_cycle();
    req2 = 2'b00;
    @(negedge clk);
    total++;
    if ({rv2, rdata2, ram_en2, io_en2} !== {2'b01, 8'h3C, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL decode_io_return rv=%b rdata=%h ram_en=%b io_en=%b required 01 3c 0 0",
               rv2, rdata2, ram_en2, io_en2);
    end
    $display("io return: rv=%b rdata=%h", rv2, rdata2);
    next_cycle();
    req2 = 2'b01; wr2 = 2'b01; a2 = {32'h0, 32'h0000_1234}; wd2 = {8'h00, 8'hA5};
    @(negedge clk);
    total++;
    if ({ack2, ram_en2, ram_wr2, ram_a2, ram_d2, io_en2} !== {2'b01, 1'b1, 1'b1, 17'h01234, 8'hA5, 1'b0}) begin
      bad++;
      $display("FAIL decode_ram_write ack=%b ram_en=%b ram_wr=%b ram_a=%h ram_d=%h io_en=%b required 01 1 1 01234 a5 0",
               ack2, ram_en2, ram_wr2, ram_a2, ram_d2, io_en2);
    end
    $display("ram write: ram_a=%h ram_d=%h", ram_a2, ram_d2);
    next_cycle();
    req2 = 2'b00; wr2 = 2'b00;
    @(negedge clk);
    total++;
    if ({rv2, rdata2} !== {2'b00, 8'h00}) begin
      bad++;
      $display("FAIL decode_write_no_rvalid rv=%b rdata=%h required 00 00", rv2, rdata2);
    end
    $display("after write: rv=%b rdata=%h", rv2, rdata2);
    next_cycle();
  endtask

  task automatic test_lock_burst();
    logic [1:0] req_t  [5];
    logic [1:0] lock_t [5];
    logic [1:0] ack_t  [5];
    req_t  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    lock_t = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    ack_t  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    wr2 = 2'b11;
    a2 = {32'h0000_0200, 32'h0000_0100};
    for (int i = 0; i < 5; i++) begin
      req2 = req_t[i]; lock2 = lock_t[i];
      @(negedge clk);
      total++;
      if (ack2 !== ack_t[i]) begin
        bad++;
        $display("FAIL lock_cycle%0d ack=%b required %b", i, ack2, ack_t[i]);
      end
      $display("lock cycle %0d: req=%b lock=%b ack=%b", i, req2, lock2, ack2);
      next_cycle();
    end
    req2 = '0; lock2 = '0; wr2 = '0;
  endtask

  task automatic test_dbg_preempt();
    logic       dbg_t  [9];
    logic [2:0] req_t  [9];
    logic [2:0] lock_t [9];
    logic [2:0] ack_t  [9];
    logic [2:0] rv_t   [9];
    logic [7:0] exp_rd;
    dbg_t  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    req_t  = '{3'b001, 3'b001, 3'b111, 3'b111, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111};
    lock_t = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    ack_t  = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b000, 3'b010, 3'b100, 3'b001, 3'b001};
    rv_t   = '{3'b000, 3'b001, 3'b001, 3'b100, 3'b100, 3'b000, 3'b010, 3'b100, 3'b001};
    do_reset();
    wr3 = 3'b000;
    a3 = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    for (int i = 0; i < 9; i++) begin
      dbg3 = dbg_t[i]; req3 = req_t[i]; lock3 = lock_t[i];
      ram_q = 8'(8'h90 + i);
      exp_rd = (rv_t[i] != 3'b000) ? 8'(8'h90 + i) : 8'h00;
      @(negedge clk);
      total++;
      if ({ack3, rv3, rdata3} !== {ack_t[i], rv_t[i], exp_rd}) begin
        bad++;
        $display("FAIL dbg_cycle%0d ack=%b rv=%b rdata=%h required %b %b %h",
                 i, ack3, rv3, rdata3, ack_t[i], rv_t[i], exp_rd);
      end
      $display("dbg cycle %0d: dbg=%b req=%b ack=%b rv=%b rdata=%h", i, dbg3, req3, ack3, rv3, rdata3);
      next_cycle();
    end
    dbg3 = 1'b0; req3 = '0; lock3 = '0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req2 = 2'b01; lock2 = 2'b01; wr2 = 2'b00;
    a2 = {32'h0000_0020, 32'h0000_0010};
    @(negedge clk);
    total++;
    if (ack2 !== 2'b01) begin
      bad++;
      $display("FAIL midrst_ack ack=%b required 01", ack2);
    end
    $display("mid-read ack: ack=%b", ack2);
    next_cycle();
    rstn_in = 1'b0;
    req2 = '0; lock2 = '0;
    @(negedge clk);
    total++;
    if ({ack2, rv2, rdata2} !== {2'b00, 2'b00, 8'h00}) begin
      bad++;
      $display("FAIL midrst_in_reset ack=%b rv=%b rdata=%h required all zero", ack2, rv2, rdata2);
    end
    $display("in reset: ack=%b rv=%b", ack2, rv2);
    @(posedge clk);
    @(negedge clk);
    rstn_in = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if ({ack2, rv2} !== {2'b00, 2'b00}) begin
      bad++;
      $display("FAIL midrst_no_rvalid ack=%b rv=%b required 00 00", ack2, rv2);
    end
    $display("after release: ack=%b rv=%b", ack2, rv2);
    next_cycle();
    req2 = 2'b10;
    @(negedge clk);
    total++;
    if ({ack2, rv2} !== {2'b10, 2'b00}) begin
      bad++;
      $display("FAIL midrst_lock_cleared ack=%b rv=%b required 10 00", ack2, rv2);
    end
    $display("post-reset grant: ack=%b rv=%b", ack2, rv2);
    next_cycle();
    req2 = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_decode();
    test_lock_burst();
    test_dbg_preempt();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised successor to the fixed two-source memory mux at the top level.
- Arbitrates N byte-wide memory masters (CPU ports, debug/HCI, future DMA) onto the shared internal RAM and memory-mapped IO space.
- Provides round-robin fairness, locked bursts, debug preemption, and tracked one-cycle read-data return routed to the issuing master.
- Sits between the masters and the ram / hci io ports, replacing the combinational cpumc_* muxing.

Parameters:
- NUM_MASTERS, 2, number of masters (2..8)
- ADDR_WIDTH, 32, master address width
- RAM_ADDR_WIDTH, 17, RAM address width; IO region decoded when a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11 (ADDR_WIDTH > RAM_ADDR_WIDTH required)
- IO_SEL_WIDTH, 3, IO register select width (low address bits)
- DBG_MASTER, NUM_MASTERS-1, index of the master preempting under dbg_active

Ports:
- clk_in  in  1  system clock
- rstn_in  in  1  reset; asynchronous and active-low
- dbg_active  in  1  debug break; only DBG_MASTER may be granted
- m_req  in  NUM_MASTERS  per-master byte request
- m_lock  in  NUM_MASTERS  hold grant for the next cycle (burst)
- m_wr  in  NUM_MASTERS  1=write, 0=read
- m_a  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*AW +: AW]
- m_wdata  in  NUM_MASTERS*8  packed write bytes
- m_ack  out  NUM_MASTERS  one-hot; request accepted this cycle
- m_rvalid  out  NUM_MASTERS  one-hot; read byte valid on m_rdata
- m_rdata  out  8  shared read-return byte
- ram_en  out  1  RAM enable
- ram_wr  out  1  RAM write (ram r_nw = ~ram_wr)
- ram_a  out  RAM_ADDR_WIDTH  RAM address
- ram_d  out  8  RAM write data
- ram_q  in  8  RAM read data, valid one cycle after a read issue
- io_en  out  1  IO enable
- io_wr  out  1  IO write
- io_sel  out  IO_SEL_WIDTH  IO register select
- io_d  out  8  IO write data
- io_q  in  8  IO read data, valid one cycle after a read issue

Behaviour:
- Reset (rstn_in low, async):
  - State=ARB, rr_ptr=0, rd_pend=0.
  - All outputs 0 while reset is asserted, including combinational enables (gated by internal reset flag).
- One transfer issued per cycle. Grant is combinational from registered state and current m_req. m_ack[g]=1 in the issue cycle; ram_*/io_* are driven from master g in that same cycle.
- Decode:
  - io region → io_en=1, ram_en=0, io_sel=a[IO_SEL_WIDTH-1:0].
  - else ram_en=1, ram_a=a[RAM_ADDR_WIDTH-1:0].
  - No grant → all enables 0.
- States:
  - ARB: grant the first requester scanning circularly from rr_ptr. On a grant to g, rr_ptr<=(g+1) mod NUM_MASTERS. If m_lock[g]=1, next state=LOCKED with owner<=g.
  - LOCKED: only owner is eligible; rr_ptr frozen. Owner with req=1 is granted. Exit to ARB when owner's lock=0 (that cycle is still granted if req=1) or req=0 (no grant that cycle).
  - DBG: entered from any state in the cycle dbg_active=1 (combinationally effective that cycle). Only DBG_MASTER is eligible; a LOCKED burst of another master is aborted with no ack. dbg_active=0 → ARB, rr_ptr unchanged.
- Read return: an acked read sets rd_pend<=1, rd_owner<=g, rd_io<=io-decode. Next cycle m_rvalid[rd_owner]=1 and m_rdata=rd_io?io_q:ram_q. Return is delivered even if the state changed (preemption, lock release). Back-to-back reads give one return per cycle. Acked writes produce no rvalid. m_rdata=0 when no rvalid.
- Invariants: m_ack and m_rvalid each at most one-hot; ram_en & io_en never both 1.
- Reset mid-operation: pending read is discarded (no rvalid after release); lock is cleared.

Test Plan:
- Reset: rstn_in=0 with m_req=2'b11 → all outputs 0; release → master 0 acked first cycle, rr_ptr=1.
- Fairness, N=2: both masters request reads continuously → acks alternate 0,1,0,1; rvalid follows each ack by exactly 1 cycle with the correct owner and ram_q byte.
- Decode: master 0 reads a=32'h0003_0004 → io_en=1, io_sel=3'd4, ram_en=0; next cycle m_rdata=io_q. Write a=32'h0000_1234 data 8'hA5 → ram_en=1, ram_wr=1, ram_a=17'h01234, ram_d=8'hA5, no rvalid.
- Lock burst: master 1 requests with lock for 4 cycles while master 0 also requests → four consecutive acks to master 1; after lock drops, master 0 acked next.
- Debug preemption, N=3, DBG_MASTER=2: master 0 in LOCKED read burst, dbg_active=1 mid-burst → master 0's in-flight read still gets rvalid; master 2 acked the same cycle; masters 0/1 starved until dbg_active=0, then arbitration resumes at the saved rr_ptr.
- Async reset mid-read: assert rstn_in the cycle after a read ack → no rvalid ever appears; state returns to ARB.
